image_sensor_emulator: RTL and testbench
========================================

Name: image_sensor_emulator

Overview:
- Transmit-side counterpart of the CMOS sensor capture path.
- Emulates the sensor's parallel output: generates pixclk, line-valid, frame-valid and 12-bit data from a frame buffer, using the same timing the capture block expects.
- On `trigger`, streams one frame read from an external synchronous image memory.
- Used as a bench/loopback source and for on-board self-test of the capture path.

Parameters:
- DIM_X, 1280, pixels per line (>=1)
- DIM_Y, 960, lines per frame (>=1)
- BIT_DEPTH, 12, pixel width
- PIXCLK_DIV, 2, clock cycles per pixclk half-period (>=2)
- H_BLANK, 8, pixclk periods with LV low between lines (>=1)
- TRIGGER_DELAY, 3840, clock cycles from trigger acceptance to earliest frame start
- ADDR_WIDTH, $clog2(DIM_X*DIM_Y), memory address width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- trigger  in  1  start-frame pulse, sampled in IDLE only
- busy  out  1  high from trigger acceptance until frame end
- done  out  1  one-cycle pulse at frame end
- error  out  1  sticky; set by trigger while busy
- errorClr  in  1  clears error
- readEnable  out  1  memory read strobe
- readAddr  out  ADDR_WIDTH  pixel address, raster order
- readData  in  BIT_DEPTH  memory data, valid one cycle after readEnable
- sensorPixclk  out  1  emulated pixel clock
- sensorLineValid  out  1  LV
- sensorFrameValid  out  1  FV
- sensorDout  out  BIT_DEPTH  pixel data

Behaviour:
- Reset (reset=0, async) values:
  - all outputs 0
  - state IDLE
  - pixclk phase counter 0
- All outputs are registered.
- Pixclk generation:
  - Free-runs whenever not in reset.
  - Phase counter runs 0..PIXCLK_DIV-1; pixclk toggles on wrap.
  - First rise at cycle PIXCLK_DIV after reset release; period is 2*PIXCLK_DIV.
- "Falling cycle" = the edge at which the pixclk register goes 1->0. "Rising cycle" = the edge at which it goes 0->1.
- LV, FV and sensorDout change only on falling cycles, so they are stable across every pixclk rise.
- sensorDout is 0 whenever LV=0.
- States: IDLE -> DELAY -> LINE -> HBLANK -> (LINE | IDLE).
  - IDLE: trigger=1 -> DELAY, busy=1, delay counter cleared, pixel/line/address counters cleared.
  - DELAY:
    - Counts clock cycles.
    - Once count >= TRIGGER_DELAY, the next falling cycle raises FV and LV, drives pixel 0, and enters LINE.
  - LINE:
    - Each falling cycle drives the next pixel.
    - After DIM_X pixels, the next falling cycle drops LV.
    - If lines remain: go to HBLANK.
    - If this was the last line: drop FV in the same cycle, pulse done, busy=0, go to IDLE.
  - HBLANK:
    - Counts H_BLANK falling cycles, including the one that dropped LV.
    - The falling cycle after that raises LV with the next line's first pixel, then LINE.
- Memory fetch:
  - The read for pixel n is issued on the rising cycle before the falling cycle that drives pixel n: readEnable=1 for one cycle, readAddr=n.
  - readData is registered into sensorDout at that falling cycle. PIXCLK_DIV>=2 guarantees the data arrives in time.
  - Addresses run 0..DIM_X*DIM_Y-1 with no gaps. The address counter never wraps within a frame.
- FV timing: FV stays high continuously from the first LV rise until the final LV fall.
- Pixel counts: exactly DIM_X pixclk rises with LV=1 per line, and DIM_Y lines per frame.
- Trigger while busy: ignored; error<=1.
- errorClr=1 clears error. If errorClr and a new error occur in the same cycle, the set wins.
- Reset mid-frame: LV, FV, sensorDout and busy drop immediately. No done pulse. Pixclk restarts from phase 0.

Optional Feature:
- Macro: IMAGE_SENSOR_TEST_PATTERN_EN.
- When defined:
  - Adds input `patternSelect` (1 bit), sampled at trigger acceptance and held for the frame.
  - patternSelect=1 drives sensorDout = (x + y) mod 2^BIT_DEPTH, where x = pixel column and y = line index.
  - In pattern mode readEnable stays 0.
  - patternSelect=0 behaves exactly as memory mode.
- When undefined: no `patternSelect` port; memory mode only.

Test Plan:
- Bench parameters: DIM_X=4, DIM_Y=3, PIXCLK_DIV=2, H_BLANK=2, TRIGGER_DELAY=8.
- Basic frame:
  - Stimulus: memory[n]=n+0x100; trigger pulse.
  - Required: capture on pixclk rises with LV&FV gives 12 pixels 0x100..0x10B in order.
  - Required: FV high for exactly 64 clocks; one done pulse at FV fall; busy low afterward.
- Timing:
  - Required: LV/FV/sensorDout change only on falling cycles.
  - Required: LV low for exactly 2 pixclk periods between lines; readAddr sequence 0..11, each read issued exactly once.
- Back-to-back:
  - Stimulus: trigger on the cycle after done.
  - Required: second frame identical; error stays 0.
- Trigger while busy:
  - Stimulus: trigger mid-frame.
  - Required: frame unaffected; error=1 until errorClr; errorClr together with a coincident trigger-while-busy leaves error=1.
- Reset mid-frame:
  - Stimulus: reset=0 during line 1.
  - Required: all outputs 0 immediately; no done pulse; a later trigger produces a full correct frame.
- With IMAGE_SENSOR_TEST_PATTERN_EN, patternSelect=1:
  - Required: line 2 pixels are 2,3,4,5; readEnable never asserted.

Source files
------------

// File: rtl/image_sensor_emulator_if.sv
// rtl/image_sensor_emulator_if.sv - image memory read port plus emulated parallel sensor output
interface image_sensor_emulator_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int BIT_DEPTH  = 12
);
    logic                  readEnable;
    logic [ADDR_WIDTH-1:0] readAddr;
    logic [BIT_DEPTH-1:0]  readData;
    logic                  sensorPixclk;
    logic                  sensorLineValid;
    logic                  sensorFrameValid;
    logic [BIT_DEPTH-1:0]  sensorDout;

    modport master (
        output readEnable, readAddr,
        input  readData,
        output sensorPixclk, sensorLineValid, sensorFrameValid, sensorDout
    );

    modport slave (
        input  readEnable, readAddr,
        output readData,
        input  sensorPixclk, sensorLineValid, sensorFrameValid, sensorDout
    );
endinterface

// File: rtl/image_sensor_emulator.sv
// rtl/image_sensor_emulator.sv - replays one frame from image memory as CMOS pixclk/LV/FV/data
// Optional IMAGE_SENSOR_TEST_PATTERN_EN adds patternSelect for an (x+y) ramp instead of memory data.
module image_sensor_emulator #(
    parameter int DIM_X         = 1280,
    parameter int DIM_Y         = 960,
    parameter int BIT_DEPTH     = 12,
    parameter int PIXCLK_DIV    = 2,
    parameter int H_BLANK       = 8,
    parameter int TRIGGER_DELAY = 3840,
    parameter int ADDR_WIDTH    = $clog2(DIM_X*DIM_Y)
) (
    input  logic clock,
    input  logic reset,
    input  logic trigger,
    output logic busy,
    output logic done,
    output logic error,
    input  logic errorClr,
`ifdef IMAGE_SENSOR_TEST_PATTERN_EN
    input  logic patternSelect,
`endif
    image_sensor_emulator_if.master bus
);
    localparam int PH_W  = $clog2(PIXCLK_DIV);
    localparam int DLY_W = $clog2(TRIGGER_DELAY + PIXCLK_DIV + 1);
    localparam int X_W   = $clog2(DIM_X + 1);
    localparam int Y_W   = $clog2(DIM_Y + 1);
    localparam int HB_W  = $clog2(H_BLANK + 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_LINE, S_HBLANK} state_t;

    state_t                state;
    logic [PH_W-1:0]       ph;
    logic                  pixclk;
    logic [DLY_W-1:0]      dly;
    logic [X_W-1:0]        x;
    logic [Y_W-1:0]        y;
    logic [HB_W-1:0]       hb;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  pend;
    logic                  lv, fv, re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [BIT_DEPTH-1:0]  dout;
    logic                  rise, fall, want;
    logic [BIT_DEPTH-1:0]  pix_val;

`ifdef IMAGE_SENSOR_TEST_PATTERN_EN
    logic pat;
    always_comb begin
        pix_val = bus.readData;
        if (pat)
            pix_val = BIT_DEPTH'(x) + BIT_DEPTH'(y);
    end
`else
    localparam logic pat = 1'b0;
    always_comb pix_val = bus.readData;
`endif

    assign rise = (ph == PH_W'(PIXCLK_DIV - 1)) && !pixclk;
    assign fall = (ph == PH_W'(PIXCLK_DIV - 1)) && pixclk;

    // Decided on the rising cycle: will the following falling cycle drive a pixel?
    always_comb begin
        want = 1'b0;
        case (state)
            S_DELAY:  want = (32'(dly) + 32'(PIXCLK_DIV)) >= 32'(TRIGGER_DELAY);
            S_LINE:   want = x < X_W'(DIM_X);
            S_HBLANK: want = hb == HB_W'(H_BLANK);
            default:  want = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            ph     <= '0;
            pixclk <= 1'b0;
            dly    <= '0;
            x      <= '0;
            y      <= '0;
            hb     <= '0;
            addr   <= '0;
            pend   <= 1'b0;
            lv     <= 1'b0;
            fv     <= 1'b0;
            re     <= 1'b0;
            raddr  <= '0;
            dout   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
`ifdef IMAGE_SENSOR_TEST_PATTERN_EN
            pat    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            re   <= 1'b0;

            if (ph == PH_W'(PIXCLK_DIV - 1)) begin
                ph     <= '0;
                pixclk <= ~pixclk;
            end else begin
                ph <= ph + 1'b1;
            end

            if (trigger && state != S_IDLE)
                error <= 1'b1;
            else if (errorClr)
                error <= 1'b0;

            if (state == S_IDLE && trigger) begin
                state <= S_DELAY;
                busy  <= 1'b1;
                dly   <= '0;
                x     <= '0;
                y     <= '0;
                hb    <= '0;
                addr  <= '0;
                pend  <= 1'b0;
`ifdef IMAGE_SENSOR_TEST_PATTERN_EN
                pat   <= patternSelect;
`endif
            end else if (state == S_DELAY && dly < DLY_W'(TRIGGER_DELAY)) begin
                dly <= dly + 1'b1;
            end

            if (rise && state != S_IDLE) begin
                pend <= want;
                if (want) begin
                    re    <= !pat;
                    raddr <= addr;
                    addr  <= addr + 1'b1;
                end
            end

            if (fall) begin
                pend <= 1'b0;
                case (state)
                    S_DELAY: if (pend) begin
                        fv    <= 1'b1;
                        lv    <= 1'b1;
                        dout  <= pix_val;
                        x     <= X_W'(1);
                        state <= S_LINE;
                    end
                    S_LINE: if (pend) begin
                        dout <= pix_val;
                        x    <= x + 1'b1;
                    end else begin
                        lv   <= 1'b0;
                        dout <= '0;
                        x    <= '0;
                        hb   <= HB_W'(1);
                        if (y == Y_W'(DIM_Y - 1)) begin
                            fv    <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            y     <= y + 1'b1;
                            state <= S_HBLANK;
                        end
                    end
                    S_HBLANK: if (pend) begin
                        lv    <= 1'b1;
                        dout  <= pix_val;
                        x     <= X_W'(1);
                        state <= S_LINE;
                    end else begin
                        hb <= hb + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.readEnable       = re;
    assign bus.readAddr         = raddr;
    assign bus.sensorPixclk     = pixclk;
    assign bus.sensorLineValid  = lv;
    assign bus.sensorFrameValid = fv;
    assign bus.sensorDout       = dout;
endmodule

// File: tb/tb_image_sensor_emulator.sv
// tb/tb_image_sensor_emulator.sv - scoreboard bench for image_sensor_emulator
module tb_image_sensor_emulator;
    localparam int DX = 4, DY = 3, BD = 12, DIV = 2, HB = 2, TD = 8, AW = 4;
    localparam int FV_CLOCKS  = (DX * DY + HB * (DY - 1)) * 2 * DIV;
    localparam int GAP_CLOCKS = HB * 2 * DIV;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic trigger = 1'b0;
    logic errorClr = 1'b0;
    logic busy, done, error;
`ifdef IMAGE_SENSOR_TEST_PATTERN_EN
    logic patternSelect = 1'b0;
`endif

    image_sensor_emulator_if #(.ADDR_WIDTH(AW), .BIT_DEPTH(BD)) bus ();

    image_sensor_emulator #(
        .DIM_X(DX), .DIM_Y(DY), .BIT_DEPTH(BD), .PIXCLK_DIV(DIV),
        .H_BLANK(HB), .TRIGGER_DELAY(TD), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset), .trigger(trigger), .busy(busy), .done(done),
        .error(error), .errorClr(errorClr),
`ifdef IMAGE_SENSOR_TEST_PATTERN_EN
        .patternSelect(patternSelect),
`endif
        .bus(bus)
    );

    always #5 clock = ~clock;

    // image memory: word n holds n + 0x100, one cycle read latency
    always @(posedge clock)
        if (bus.readEnable)
            bus.readData <= 12'h100 + 12'(bus.readAddr);

    int n_checks = 0, n_pass = 0;
    int px_q[$], addr_q[$];
    int stab_err = 0, gap_err = 0, multi_re = 0, rd_extra = 0, px_extra = 0;
    int done_cnt = 0, fv_len = 0, fv_run = 0, gap_run = 0;
    logic prev_valid = 1'b0, prev_pclk = 1'b0, prev_lv = 1'b0, prev_fv = 1'b0, prev_re = 1'b0;
    logic [BD-1:0] prev_dout = '0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !(prev_pclk && !bus.sensorPixclk) &&
                (bus.sensorLineValid != prev_lv || bus.sensorFrameValid != prev_fv ||
                 bus.sensorDout != prev_dout))
                stab_err++;
            if (!bus.sensorLineValid && bus.sensorDout != '0)
                stab_err++;
            if (prev_valid && !prev_pclk && bus.sensorPixclk &&
                bus.sensorLineValid && bus.sensorFrameValid) begin
                if (px_q.size() == 0) px_extra++;
                else check("pixel", int'(bus.sensorDout), px_q.pop_front());
            end
            if (bus.sensorFrameValid && !prev_fv) fv_run = 0;
            if (bus.sensorFrameValid) fv_run++;
            if (!bus.sensorFrameValid && prev_fv) fv_len = fv_run;
            if (bus.sensorFrameValid && !bus.sensorLineValid) gap_run++;
            if (bus.sensorLineValid && !prev_lv && prev_fv && gap_run != GAP_CLOCKS) gap_err++;
            if (bus.sensorLineValid) gap_run = 0;
            if (bus.readEnable) begin
                if (prev_re) multi_re++;
                if (addr_q.size() == 0) rd_extra++;
                else check("rd_addr", int'(bus.readAddr), addr_q.pop_front());
            end
            if (done) done_cnt++;
            prev_valid = 1'b1;
        end
        prev_pclk = bus.sensorPixclk;
        prev_lv   = bus.sensorLineValid;
        prev_fv   = bus.sensorFrameValid;
        prev_dout = bus.sensorDout;
        prev_re   = bus.readEnable;
    end

    task automatic run_frame(input bit pat, input int trig_at, input bit clr_too, input int exp_err);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        stab_err = 0; gap_err = 0; multi_re = 0; rd_extra = 0; px_extra = 0; fv_len = 0;
        for (int yy = 0; yy < DY; yy++)
            for (int xx = 0; xx < DX; xx++) begin
                px_q.push_back(pat ? (xx + yy) : (12'h100 + yy * DX + xx));
                if (!pat) addr_q.push_back(yy * DX + xx);
            end
`ifdef IMAGE_SENSOR_TEST_PATTERN_EN
        patternSelect = pat;
`endif
        trigger = 1'b1;
        @(negedge clock); #1;
        trigger = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            trigger  = (c == trig_at);
            errorClr = (c == trig_at) && clr_too;
        end
        trigger  = 1'b0;
        errorClr = 1'b0;
        check("done_seen", seen, 1);
        check("done_count", done_cnt - d0, 1);
        check("busy_after", busy, 0);
        check("fv_clocks", fv_len, FV_CLOCKS);
        check("px_left", px_q.size(), 0);
        check("px_extra", px_extra, 0);
        check("rd_left", addr_q.size(), 0);
        check("rd_extra", rd_extra, 0);
        check("re_multi", multi_re, 0);
        check("stable_on_fall", stab_err, 0);
        check("lv_gap", gap_err, 0);
        check("error", error, exp_err);
        px_q.delete();
        addr_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_re"}, bus.readEnable, 0);
        check({tag, "_pclk"}, bus.sensorPixclk, 0);
        check({tag, "_lv"}, bus.sensorLineValid, 0);
        check({tag, "_fv"}, bus.sensorFrameValid, 0);
        check({tag, "_dout"}, int'(bus.sensorDout), 0);
    endtask

    initial begin
        int d0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_idle_outputs("reset");
        check("reset_error", error, 0);
        reset = 1'b1;
        @(negedge clock); #1;

        run_frame(1'b0, -1, 1'b0, 0);
        @(negedge clock); #1;
        check("done_width", done, 0);
        run_frame(1'b0, -1, 1'b0, 0);

        run_frame(1'b0, 20, 1'b0, 1);
        repeat (3) @(negedge clock);
        #1;
        check("error_sticky", error, 1);
        errorClr = 1'b1;
        @(negedge clock); #1;
        errorClr = 1'b0;
        check("error_clr", error, 0);

        run_frame(1'b0, 30, 1'b1, 1);
        errorClr = 1'b1;
        @(negedge clock); #1;
        errorClr = 1'b0;

        trigger = 1'b1;
        @(negedge clock); #1;
        trigger = 1'b0;
        repeat (40) @(negedge clock);
        #1;
        check("midframe_busy", busy, 1);
        check("midframe_fv", bus.sensorFrameValid, 1);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;
        repeat (20) @(negedge clock);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_fv", bus.sensorFrameValid, 0);
        run_frame(1'b0, -1, 1'b0, 0);

`ifdef IMAGE_SENSOR_TEST_PATTERN_EN
        run_frame(1'b1, -1, 1'b0, 0);
        patternSelect = 1'b0;
        run_frame(1'b0, -1, 1'b0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
